// File: rtl/sys_seq_ctrl.sv
// Power-up reset sequencer with programmable strobe dividers and a heartbeat.
// Defining SEQ_STATUS_EN adds the seq_status debug port and the lock-loss counter.

module sys_seq_div #(
   parameter int DIV = 2
) (
   input  logic clk,
   input  logic areset_n,
   output logic pulse
);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          pulse_q, pulse_d;

   always_comb begin
      pulse_d = (cnt_q == CW'(DIV - 1));
      cnt_d   = pulse_d ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;
endmodule

module sys_seq_ctrl #(
   parameter int NUM_STAGE               = 3,
   parameter int STAGE_DLY_CYC           = 10_000,
   parameter int LOCK_FILT_CYC           = 1_000,
   parameter int NUM_STROBE              = 2,
   parameter int STROBE_DIV [NUM_STROBE] = '{250, 100_000},
   parameter int HB_HALF_CYC             = 50_000_000
) (
   input  logic                  clk,
   input  logic                  areset_n,
   input  logic                  pll_locked,
   input  logic                  soft_rst,
   output logic [NUM_STAGE-1:0]  stage_rst,
   output logic                  seq_done,
   output logic [NUM_STROBE-1:0] strobe,
   output logic                  heartbeat
`ifdef SEQ_STATUS_EN
   ,
   output logic [15:0]           seq_status
`endif
);
   localparam int IDX_W = (NUM_STAGE > 1)     ? $clog2(NUM_STAGE)     : 1;
   localparam int DLY_W = (STAGE_DLY_CYC > 1) ? $clog2(STAGE_DLY_CYC) : 1;
   localparam int LCK_W = (LOCK_FILT_CYC > 1) ? $clog2(LOCK_FILT_CYC) : 1;
   localparam int HB_W  = (HB_HALF_CYC > 1)   ? $clog2(HB_HALF_CYC)   : 1;

   typedef enum logic [1:0] {
      S_HOLD  = 2'd0,
      S_STAGE = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DLY_W-1:0]     dly_q, dly_d;
   logic [LCK_W-1:0]     lock_cnt_q, lock_cnt_d;
   logic [1:0]           sync_q;
   logic [NUM_STAGE-1:0] stage_rst_q, stage_rst_d;
   logic                 seq_done_q, seq_done_d;
   logic [HB_W-1:0]      hb_cnt_q, hb_cnt_d;
   logic                 hb_q, hb_d;
   logic                 lock_s, abort;

   assign lock_s = sync_q[1];
   assign abort  = !lock_s || soft_rst;

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state_q     <= S_HOLD;
         idx_q       <= '0;
         dly_q       <= '0;
         lock_cnt_q  <= '0;
         sync_q      <= '0;
         stage_rst_q <= '1;
         seq_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         dly_q       <= dly_d;
         lock_cnt_q  <= lock_cnt_d;
         sync_q      <= {sync_q[0], pll_locked};
         stage_rst_q <= stage_rst_d;
         seq_done_q  <= seq_done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      dly_d      = dly_q;
      lock_cnt_d = lock_cnt_q;
      case (state_q)
         S_HOLD: begin
            if (abort) begin
               lock_cnt_d = '0;
            end else if (lock_cnt_q == LCK_W'(LOCK_FILT_CYC - 1)) begin
               state_d    = S_STAGE;
               lock_cnt_d = '0;
               idx_d      = '0;
               dly_d      = '0;
            end else begin
               lock_cnt_d = lock_cnt_q + LCK_W'(1);
            end
         end
         S_STAGE: begin
            if (abort) begin
               state_d    = S_HOLD;
               idx_d      = '0;
               dly_d      = '0;
               lock_cnt_d = '0;
            end else if (dly_q == DLY_W'(STAGE_DLY_CYC - 1)) begin
               dly_d = '0;
               if (idx_q == IDX_W'(NUM_STAGE - 1)) state_d = S_RUN;
               else                                idx_d   = idx_q + IDX_W'(1);
            end else begin
               dly_d = dly_q + DLY_W'(1);
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d    = S_HOLD;
               idx_d      = '0;
               dly_d      = '0;
               lock_cnt_d = '0;
            end
         end
         default: state_d = S_HOLD;
      endcase
   end

   // Outputs decode the next state so they leave a flop and can never glitch.
   always_comb begin
      stage_rst_d = '1;
      seq_done_d  = 1'b0;
      case (state_d)
         S_STAGE: for (int k = 0; k < NUM_STAGE; k++) stage_rst_d[k] = (k >= int'(idx_d));
         S_RUN: begin
            stage_rst_d = '0;
            seq_done_d  = 1'b1;
         end
         default: ;
      endcase
   end

   assign stage_rst = stage_rst_q;
   assign seq_done  = seq_done_q;

   for (genvar k = 0; k < NUM_STROBE; k++) begin : g_strb
      sys_seq_div #(.DIV(STROBE_DIV[k])) u_div (
         .clk      (clk),
         .areset_n (areset_n),
         .pulse    (strobe[k])
      );
   end

   always_comb begin
      hb_d     = hb_q;
      hb_cnt_d = hb_cnt_q + HB_W'(1);
      if (hb_cnt_q == HB_W'(HB_HALF_CYC - 1)) begin
         hb_cnt_d = '0;
         hb_d     = !hb_q;
      end
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         hb_cnt_q <= '0;
         hb_q     <= 1'b0;
      end else begin
         hb_cnt_q <= hb_cnt_d;
         hb_q     <= hb_d;
      end
   end

   assign heartbeat = hb_q;

`ifdef SEQ_STATUS_EN
   logic [10:0] loss_cnt_q, loss_cnt_d;

   always_comb begin
      loss_cnt_d = loss_cnt_q;
      if (state_q != S_HOLD && !lock_s && loss_cnt_q != 11'h7FF)
         loss_cnt_d = loss_cnt_q + 11'd1;
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) loss_cnt_q <= '0;
      else           loss_cnt_q <= loss_cnt_d;
   end

   assign seq_status = {state_q, 3'(idx_q), loss_cnt_q};
`endif
endmodule

// File: tb/tb_sys_seq_ctrl.sv
// Randomized bench for sys_seq_ctrl against a timing-rule reference model.

module tb_sys_seq_ctrl;
   localparam int NS   = 3;
   localparam int SD   = 8;
   localparam int LF   = 4;
   localparam int NSTR = 2;
   localparam int DIVS [NSTR] = '{5, 12};
   localparam int HB   = 10;

   logic            clk, areset_n, pll_locked, soft_rst;
   logic [NS-1:0]   stage_rst;
   logic            seq_done, heartbeat;
   logic [NSTR-1:0] strobe;
`ifdef SEQ_STATUS_EN
   logic [15:0]     seq_status;
`endif

   sys_seq_ctrl #(
      .NUM_STAGE     (NS),
      .STAGE_DLY_CYC (SD),
      .LOCK_FILT_CYC (LF),
      .NUM_STROBE    (NSTR),
      .STROBE_DIV    (DIVS),
      .HB_HALF_CYC   (HB)
   ) dut (
      .clk        (clk),
      .areset_n   (areset_n),
      .pll_locked (pll_locked),
      .soft_rst   (soft_rst),
      .stage_rst  (stage_rst),
      .seq_done   (seq_done),
      .strobe     (strobe),
      .heartbeat  (heartbeat)
`ifdef SEQ_STATUS_EN
      ,
      .seq_status (seq_status)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errs, checks;
   // Model: n = edges since reset release, act/t0 = sequencing active since edge t0.
   int n, t0, run, loss;
   bit act;
   bit hist[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, n, got, exp);
      end
   endtask

   task automatic model_step();
      bit lk;
      lk = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
      n++;
      if (act) begin
         if (soft_rst || !lk) begin
            act = 0;
            run = 0;
            if (!lk && loss < 2047) loss++;
         end
      end else if (soft_rst || !lk) begin
         run = 0;
      end else begin
         run++;
         if (run == LF) begin
            act = 1;
            t0  = n;
            run = 0;
         end
      end
      hist.push_back(pll_locked);
      if (hist.size() > 4) void'(hist.pop_front());
   endtask

   task automatic cycle();
      logic [NS-1:0]   sr;
      logic [NSTR-1:0] st;
      logic            dn, hb;
      int              el;
      @(posedge clk);
      model_step();
      #1;
      sr = '1;
      dn = 1'b0;
      if (act) begin
         el = n - t0;
         for (int k = 0; k < NS; k++) if (el >= (k + 1) * SD) sr[k] = 1'b0;
         dn = (el >= NS * SD);
      end
      for (int k = 0; k < NSTR; k++) st[k] = ((n % DIVS[k]) == 0);
      hb = ((n / HB) % 2) == 1;
      chk("stage_rst", 32'(stage_rst), 32'(sr));
      chk("seq_done",  32'(seq_done),  32'(dn));
      chk("strobe",    32'(strobe),    32'(st));
      chk("heartbeat", 32'(heartbeat), 32'(hb));
`ifdef SEQ_STATUS_EN
      chk("loss_cnt",  32'(seq_status[10:0]), 32'(loss));
`endif
   endtask

   task automatic check_reset_vals();
      chk("rst_stage_rst", 32'(stage_rst), 32'({NS{1'b1}}));
      chk("rst_seq_done",  32'(seq_done),  32'(0));
      chk("rst_strobe",    32'(strobe),    32'(0));
      chk("rst_heartbeat", 32'(heartbeat), 32'(0));
`ifdef SEQ_STATUS_EN
      chk("rst_status",    32'(seq_status), 32'(0));
`endif
   endtask

   task automatic async_rst();
      #2 areset_n = 1'b0;
      #1 check_reset_vals();
      repeat (2) @(posedge clk);
      @(negedge clk);
      areset_n = 1'b1;
      n = 0; act = 0; run = 0; loss = 0;
      hist.delete();
   endtask

   task automatic wait_elapsed(input int el);
      for (int i = 0; i < 80 && !(act && (n - t0) == el); i++) cycle();
   endtask

   initial begin
      #500_000;
      $display("FAIL timeout cyc=%0d", n);
      $fatal(1);
   end

   initial begin
      bit pat [16];
      errs = 0; checks = 0;
      n = 0; act = 0; run = 0; loss = 0;
      areset_n = 1'b1; pll_locked = 1'b1; soft_rst = 1'b0;
      #2 areset_n = 1'b0;
      #2 check_reset_vals();
      @(negedge clk);
      areset_n = 1'b1;

      // Power-up with steady lock through to RUN.
      repeat (40) cycle();

      // Lock loss, then a glitchy relock.
      pll_locked = 1'b0;
      repeat (5) cycle();
      for (int i = 0; i < 16; i++) pat[i] = (i != 3);
      for (int i = 0; i < 16; i++) begin
         pll_locked = pat[i];
         cycle();
      end
      repeat (30) cycle();

      // Single-cycle lock drop in RUN.
      pll_locked = 1'b0;
      cycle();
      pll_locked = 1'b1;
      repeat (45) cycle();

      // Soft reset pulse during stage idx=1.
      soft_rst = 1'b1;
      repeat (3) cycle();
      soft_rst = 1'b0;
      wait_elapsed(12);
      soft_rst = 1'b1;
      cycle();
      soft_rst = 1'b0;
      repeat (40) cycle();

      // Soft reset held keeps the sequencer parked.
      soft_rst = 1'b1;
      repeat (8) cycle();
      soft_rst = 1'b0;
      repeat (40) cycle();

      // Asynchronous reset during stage idx=2.
      pll_locked = 1'b0;
      repeat (3) cycle();
      pll_locked = 1'b1;
      wait_elapsed(20);
      async_rst();
      repeat (40) cycle();

      // Random lock drops, soft resets and occasional async resets.
      for (int i = 0; i < 3000; i++) begin
         pll_locked = ($urandom_range(0, 79) != 0);
         soft_rst   = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 699) == 0) async_rst();
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
